pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Stall/flush sequencer for the five-stage pipeline. Drives the load enables of the PC register and the IF_ID/ID_EX/EX_MEM/MEM_WB pipeline registers (PC, IR and control-word shift chains) so they advance in lockstep, or hold, or take a bubble. Tracks outstanding I-cache and D-cache requests whose single-cycle responses can arrive in either order. Also inserts load-use bubbles and branch flushes.

## Interface
Parameters:
- NOP_INSTR, 32'h00000013: instruction the datapath writes into IF_ID IR on flush.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-low reset (reset == 0 resets on posedge clk).
- imem_req  in  1  fetch request in flight this cycle (held by the datapath until the pipeline advances).
- imem_resp  in  1  I-cache response, one-cycle pulse.
- dmem_req  in  1  MEM-stage load/store in flight (held until advance).
- dmem_resp  in  1  D-cache response, one-cycle pulse.
- ex_mem_read  in  1  instruction in ID_EX is a load.
- ex_rd  in  5  destination register of the ID_EX instruction.
- id_rs1, id_rs2  in  5 each  source registers of the IF_ID instruction.
- id_use_rs1, id_use_rs2  in  1 each  the IF_ID instruction reads rs1/rs2.
- ex_br_taken  in  1  EX resolves a taken branch or jump (redirect).
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables.
- flush_if_id  out  1  IF_ID IR takes NOP_INSTR on this load.
- bubble_id_ex  out  1  ID_EX control word takes all-zero on this load.
- ihold_en, dhold_en  out  1 each  capture the early-arriving cache read data into the datapath hold register.
- use_ihold, use_dhold  out  1 each  the datapath selects held data instead of live cache data.
- stall_cycles  out  32  cycles with the pipeline frozen.
- bubble_count  out  32  bubbles inserted.

## Operation
- States: RUN, WAIT.
  - RUN → WAIT when any requested response is not present in the same cycle.
  - WAIT → RUN in the cycle when the last outstanding response arrives. That cycle is the advance cycle.
- Flags i_done and d_done are set when imem_resp or dmem_resp arrives in WAIT without completing the wait. Both clear on advance.
- On setting i_done, assert ihold_en for that cycle. use_ihold is asserted while i_done = 1. The d side behaves the same way with dmem_resp, dhold_en, d_done and use_dhold.
- advance = all requested responses are present now or already flagged. It is 1 when no request is outstanding.
- Load-use hazard = ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- On advance, highest priority first:
  1. ex_br_taken: all loads = 1, flush_if_id = 1, bubble_id_ex = 1.
  2. Load-use: load_pc = 0, load_if_id = 0, the other loads = 1, bubble_id_ex = 1.
  3. Otherwise all loads = 1, flush and bubble = 0.
- Without advance, all loads, flush_if_id and bubble_id_ex are 0.
- ex_br_taken during a stall takes effect only in the advance cycle. The datapath holds it stable until then.
- Reset: state = RUN, i_done = d_done = 0, counters = 0. All outputs read 0 in the cycle reset is asserted. Reset in WAIT discards the outstanding flags; responses arriving later are ignored until a new request.

## Timing
- All enables are combinational from inputs and state. Zero-cycle latency: a response arriving with no other request outstanding advances in the same cycle.
- A single miss of N cycles gives N−1 frozen cycles, then advance in the response cycle.
- Simultaneous imem_resp and dmem_resp: advance in that cycle, no hold used.
- Split responses: hold is captured in the first response cycle, advance in the second.
- A response pulse with its req = 0 is ignored.
- bubble_count increments by 1 per cycle with bubble_id_ex = 1.
- stall_cycles increments per cycle with (imem_req | dmem_req) & ~advance.
- Both counters wrap at 2^32.

## Configuration
- PIPELINE_CTRL_PERF_EN defined: stall_cycles and bubble_count are implemented as described.
- PIPELINE_CTRL_PERF_EN undefined: both ports are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset: drive reset = 0 for 2 cycles with imem_req = 1 and imem_resp = 1 → all loads 0, counters 0, state RUN.
- Hit path: imem_req = 1 and imem_resp = 1 every cycle for 10 cycles → all five loads = 1 each cycle, stall_cycles = 0.
- Split miss: imem_req = dmem_req = 1; imem_resp at cycle 2, dmem_resp at cycle 5 → ihold_en pulses at cycle 2; use_ihold = 1 in cycles 3–5; advance only at cycle 5; stall_cycles = 4.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1, hit → load_pc = load_if_id = 0, bubble_id_ex = 1, bubble_count = 1.
- Branch beats load-use: ex_br_taken = 1 together with the load-use hazard → all loads = 1, flush_if_id = 1, bubble_id_ex = 1.
- Reset mid-miss: dmem_req = 1 without response for 3 cycles, then reset = 0 for 1 cycle, then a stray dmem_resp with dmem_req = 0 → state RUN, no advance, d_done = 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// Generates the PC / IF_ID / ID_EX / EX_MEM / MEM_WB load enables, tracks
// I- and D-cache responses that may come back in either order, and inserts
// load-use bubbles and branch flushes.
// Optional feature macro: PIPELINE_CTRL_PERF_EN (stall/bubble counters).
module pipeline_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_br_taken,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        bubble_id_ex,
    output logic        ihold_en,
    output logic        dhold_en,
    output logic        use_ihold,
    output logic        use_dhold,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count
);

    typedef enum logic {RUN, WAIT} state_t;

    state_t state;
    logic   i_done, d_done;
    logic   i_ok, d_ok, advance, hazard, i_first, d_first;

    // Advance / hazard evaluation and the enable decode (purely combinational)
    always_comb begin
        // A side is satisfied when it has no request, or its response is here now or was held
        i_ok    = ~imem_req | imem_resp | i_done;
        d_ok    = ~dmem_req | dmem_resp | d_done;
        advance = i_ok & d_ok;
        hazard  = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        // First response of a split pair: capture it, the pipeline cannot move yet
        i_first = imem_req & imem_resp & ~i_done & ~advance;
        d_first = dmem_req & dmem_resp & ~d_done & ~advance;

        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        ihold_en     = 1'b0;
        dhold_en     = 1'b0;
        use_ihold    = 1'b0;
        use_dhold    = 1'b0;

        if (reset) begin
            if (advance) begin
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                if (ex_br_taken) begin
                    // Redirect squashes both the fetched and the decoded instruction
                    load_pc      = 1'b1;
                    load_if_id   = 1'b1;
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (hazard) begin
                    // Hold PC and IF_ID, let the load move on ahead of a bubble
                    bubble_id_ex = 1'b1;
                end else begin
                    load_pc    = 1'b1;
                    load_if_id = 1'b1;
                end
            end
            ihold_en  = i_first;
            dhold_en  = d_first;
            use_ihold = (state == WAIT) & i_done;
            use_dhold = (state == WAIT) & d_done;
        end
    end

    // RUN/WAIT sequencer with the held-response flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            case (state)
                RUN:     if (!advance) state <= WAIT;
                WAIT:    if (advance)  state <= RUN;
                default: state <= RUN;
            endcase
            if (advance) begin
                i_done <= 1'b0;
                d_done <= 1'b0;
            end else begin
                if (i_first) i_done <= 1'b1;
                if (d_first) d_done <= 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_q, bubble_q;

    // Performance counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if ((imem_req | dmem_req) & ~advance) stall_q <= stall_q + 32'd1;
            if (bubble_id_ex)                     bubble_q <= bubble_q + 32'd1;
        end
    end

    // Counters read zero while reset is held, like every other output
    assign stall_cycles = reset ? stall_q  : '0;
    assign bubble_count = reset ? bubble_q : '0;
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a behavioural model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req = 1'b0, imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
    logic        ex_mem_read = 1'b0, ex_br_taken = 1'b0;
    logic [4:0]  ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, bubble_id_ex, ihold_en, dhold_en, use_ihold, use_dhold;
    logic [31:0] stall_cycles, bubble_count;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_br_taken(ex_br_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .ihold_en(ihold_en), .dhold_en(dhold_en),
        .use_ihold(use_ihold), .use_dhold(use_dhold),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Inputs, then expected outputs (ld = {pc, if_id, id_ex, ex_mem, mem_wb})
    typedef struct packed {
        logic       r, ir, irs, dr, drs, mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br;
        logic [4:0] ld;
        logic       fl, bb, ih, ui, dh, ud;
    } vec_t;

    localparam logic [4:0] L0 = 5'b00000, LA = 5'b11111, LU = 5'b00111;

    int errors = 0;
    int checks = 0;

    // Model state: which responses have been received early, and event counts
    bit          m_igot, m_dgot;
    int unsigned m_stall, m_bub;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected outputs straight from the rules: the pipeline moves only when
    // every side that asked for data has it; then branch > load-use > normal.
    function automatic logic [10:0] model_out(input vec_t v);
        bit          need_i, need_d, have_i, have_d, moves, lu;
        logic [4:0]  ld;
        bit          fl, bb, ih, dh;
        need_i = v.ir;
        need_d = v.dr;
        have_i = !need_i || v.irs || m_igot;
        have_d = !need_d || v.drs || m_dgot;
        moves  = have_i && have_d;
        lu     = v.mr && v.rd != 0 &&
                 ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        ld = L0; fl = 0; bb = 0;
        if (moves) begin
            if (v.br)      begin ld = LA; fl = 1; bb = 1; end
            else if (lu)   begin ld = LU; bb = 1; end
            else           ld = LA;
        end
        ih = need_i && v.irs && !m_igot && !moves;
        dh = need_d && v.drs && !m_dgot && !moves;
        if (!v.r) return '0;
        return {ld, fl, bb, ih, m_igot, dh, m_dgot};
    endfunction

    task automatic model_update(input vec_t v, input logic [10:0] o);
        bit moves;
        moves = (o[10:6] != L0);
        if (!v.r) begin
            m_igot = 0; m_dgot = 0; m_stall = 0; m_bub = 0;
        end else begin
            if ((v.ir || v.dr) && !moves) m_stall++;
            if (o[4]) m_bub++;
            if (moves) begin m_igot = 0; m_dgot = 0; end
            else begin
                if (o[3]) m_igot = 1;
                if (o[1]) m_dgot = 1;
            end
        end
    endtask

    // One cycle: drive, compare combinational outputs and counters, advance model
    task automatic step(input vec_t v, input string nm, input bit use_table);
        logic [10:0] act, exp, mo;
        logic [31:0] es, eb;
        @(posedge clk); #1;
        reset = v.r; imem_req = v.ir; imem_resp = v.irs; dmem_req = v.dr; dmem_resp = v.drs;
        ex_mem_read = v.mr; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_br_taken = v.br;
        @(negedge clk);
        act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, bubble_id_ex, ihold_en, use_ihold, dhold_en, use_dhold};
        mo  = model_out(v);
        exp = use_table ? {v.ld, v.fl, v.bb, v.ih, v.ui, v.dh, v.ud} : mo;
        chk({nm, " enables"}, {53'd0, act}, {53'd0, exp});
`ifdef PIPELINE_CTRL_PERF_EN
        es = v.r ? m_stall : 32'd0;
        eb = v.r ? m_bub   : 32'd0;
`else
        es = 32'd0;
        eb = 32'd0;
`endif
        chk({nm, " stall_cycles"}, {32'd0, stall_cycles}, {32'd0, es});
        chk({nm, " bubble_count"}, {32'd0, bubble_count}, {32'd0, eb});
        model_update(v, mo);
    endtask

    vec_t tbl[$];
    vec_t idle;
    vec_t rv;
    logic [31:0] s0, b0, exp_d;

    initial begin
        idle = vec_t'{1,0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,0,0,0};
        // reset held with a hit on the bus: nothing loads
        repeat (2) tbl.push_back(vec_t'{0,1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,0});
        // hit path
        repeat (10) tbl.push_back(vec_t'{1,1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,0,0,0});
        // load-use on rs2 with a hit, then on rs1 with no request
        tbl.push_back(vec_t'{1,1,1,0,0,1, 5'd5,5'd0,5'd5, 0,1,0, LU,0,1,0,0,0,0});
        tbl.push_back(vec_t'{1,0,0,0,0,1, 5'd3,5'd3,5'd9, 1,0,0, LU,0,1,0,0,0,0});
        // branch beats load-use; branch alone
        tbl.push_back(vec_t'{1,1,1,0,0,1, 5'd5,5'd0,5'd5, 0,1,1, LA,1,1,0,0,0,0});
        tbl.push_back(vec_t'{1,1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, LA,1,1,0,0,0,0});
        // no hazard: x0 dest, source not used, not a load
        tbl.push_back(vec_t'{1,0,0,0,0,1, 5'd0,5'd0,5'd0, 1,1,0, LA,0,0,0,0,0,0});
        tbl.push_back(vec_t'{1,0,0,0,0,1, 5'd5,5'd5,5'd5, 0,0,0, LA,0,0,0,0,0,0});
        tbl.push_back(vec_t'{1,1,1,0,0,0, 5'd5,5'd5,5'd0, 1,0,0, LA,0,0,0,0,0,0});
        // both miss, then both respond together: advance, no hold
        tbl.push_back(vec_t'{1,1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,0});
        tbl.push_back(vec_t'{1,1,1,1,1,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,0,0,0});
        // D returns first, I second
        tbl.push_back(vec_t'{1,1,0,1,1,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,1,0});
        tbl.push_back(vec_t'{1,1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,1});
        tbl.push_back(vec_t'{1,1,1,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,0,0,1});
        // stray response with no request is ignored
        tbl.push_back(vec_t'{1,0,1,0,1,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,0,0,0});
        // branch during a stall waits for the advance cycle
        tbl.push_back(vec_t'{1,1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, L0,0,0,0,0,0,0});
        tbl.push_back(vec_t'{1,1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, LA,1,1,0,0,0,0});

        m_igot = 0; m_dgot = 0; m_stall = 0; m_bub = 0;
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i), 1'b1);

        // split miss: I at cycle 2, D at cycle 5
        s0 = stall_cycles;
        step(vec_t'{1,1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,0}, "split c1", 1'b1);
        step(vec_t'{1,1,1,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,1,0,0,0}, "split c2", 1'b1);
        step(vec_t'{1,1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,1,0,0}, "split c3", 1'b1);
        step(vec_t'{1,1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,1,0,0}, "split c4", 1'b1);
        step(vec_t'{1,1,0,1,1,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,1,0,0}, "split c5", 1'b1);
        step(idle, "split idle", 1'b1);
`ifdef PIPELINE_CTRL_PERF_EN
        exp_d = 32'd4;
`else
        exp_d = 32'd0;
`endif
        chk("split stall delta", {32'd0, stall_cycles - s0}, {32'd0, exp_d});

        // single load-use bubble adds one to bubble_count
        b0 = bubble_count;
        step(vec_t'{1,1,1,0,0,1, 5'd5,5'd0,5'd5, 0,1,0, LU,0,1,0,0,0,0}, "lu single", 1'b1);
        step(idle, "lu idle", 1'b1);
`ifdef PIPELINE_CTRL_PERF_EN
        exp_d = 32'd1;
`else
        exp_d = 32'd0;
`endif
        chk("bubble delta", {32'd0, bubble_count - b0}, {32'd0, exp_d});

        // reset mid-miss drops the pending state; a later stray response is ignored
        repeat (3) step(vec_t'{1,0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,0}, "mid miss", 1'b1);
        step(vec_t'{0,0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,0}, "mid reset", 1'b1);
        step(vec_t'{1,0,0,0,1,0, 5'd0,5'd0,5'd0, 0,0,0, LA,0,0,0,0,0,0}, "stray dresp", 1'b1);
        step(vec_t'{1,0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, L0,0,0,0,0,0,0}, "d_done clear", 1'b1);
        step(idle, "post idle", 1'b1);

        // random stimulus against the model
        for (int n = 0; n < 600; n++) begin
            rv     = '0;
            rv.r   = ($urandom_range(0, 39) != 0);
            rv.ir  = $urandom_range(0, 1);
            rv.irs = ($urandom_range(0, 2) == 0);
            rv.dr  = $urandom_range(0, 1);
            rv.drs = ($urandom_range(0, 2) == 0);
            rv.mr  = $urandom_range(0, 1);
            rv.rd  = 5'($urandom_range(0, 3));
            rv.rs1 = 5'($urandom_range(0, 3));
            rv.rs2 = 5'($urandom_range(0, 3));
            rv.u1  = $urandom_range(0, 1);
            rv.u2  = $urandom_range(0, 1);
            rv.br  = ($urandom_range(0, 7) == 0);
            step(rv, $sformatf("rand%0d", n), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
